// File: rtl/seq_multiplier_5b.sv
// seq_multiplier_5b: unsigned 5x5 shift-and-add multiplier reusing one 5-bit prefix adder
module prefixadder (
    input  logic [4:0] a,
    input  logic [4:0] b,
    input  logic       cin,
    output logic [4:0] sum,
    output logic       cout
);
    logic [4:0] x, g0, p0, g1, p1, g2, p2, g3, p3, c;
    always_comb begin
        x  = a ^ b;
        g0 = a & b;
        p0 = x;
        g1 = g0 | (p0 & {g0[3:0], 1'b0});
        p1 = p0 & {p0[3:0], 1'b1};
        g2 = g1 | (p1 & {g1[2:0], 2'b0});
        p2 = p1 & {p1[2:0], 2'b11};
        g3 = g2 | (p2 & {g2[0], 4'b0});
        p3 = p2 & {p2[0], 4'b1111};
        c  = g3 | (p3 & {5{cin}});
        sum  = x ^ {c[3:0], cin};
        cout = c[4];
    end
endmodule

module seq_multiplier_5b #(
    parameter int WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    if (WIDTH != 5) begin : g_width_check
        $error("seq_multiplier_5b supports only WIDTH=5");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state_q, state_d;
    logic [4:0] mcand_q, mcand_d, acc_q, acc_d, mq_q, mq_d, s;
    logic [2:0] cnt_q, cnt_d;
    logic [9:0] product_q, product_d;
    logic       c;

    prefixadder u_add (
        .a    (acc_q),
        .b    (mq_q[0] ? mcand_q : 5'd0),
        .cin  (1'b0),
        .sum  (s),
        .cout (c)
    );

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        if (state_q == RUN) begin
            acc_d = {c, s[4:1]};
            mq_d  = {s[0], mq_q[4:1]};
            cnt_d = (cnt_q == 3'd4) ? 3'd0 : cnt_q + 3'd1;
            if (cnt_q == 3'd4) begin
                product_d = {c, s[4:1], s[0], mq_q[4:1]};
                state_d   = DONE;
            end
        end else if (start) begin
            mcand_d = a;
            mq_d    = b;
            acc_d   = 5'd0;
            cnt_d   = 3'd0;
            state_d = RUN;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            mq_q      <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign product = product_q;
endmodule

// File: tb/tb_seq_multiplier_5b.sv
// tb_seq_multiplier_5b: countdown/arithmetic reference model plus directed and random checks
module tb_seq_multiplier_5b;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [4:0] a = '0, b = '0;
    logic       busy, done;
    logic [9:0] product;

    int total = 0, passed = 0;
    int m_left = 0, m_done = 0, m_prod = 0, m_pend = 0, m_completions = 0;
    int dut_dones = 0;

    seq_multiplier_5b dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .product(product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s got %0d want %0d", name, got, exp);
    endtask

    // Model: an accepted operation stays busy for 5 cycles, then shows a*b with a one-cycle done.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0;
            m_done <= 0;
            m_prod <= 0;
        end else if (m_left == 0) begin
            m_done <= 0;
            if (start) begin
                m_left <= 5;
                m_pend <= int'(a) * int'(b);
            end
        end else begin
            m_left <= m_left - 1;
            m_done <= (m_left == 1) ? 1 : 0;
            if (m_left == 1) begin
                m_prod <= m_pend;
                m_completions <= m_completions + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", int'(busy), int'(m_left != 0));
            chk("done", int'(done), m_done);
            chk("product", int'(product), m_prod);
            if (done) dut_dones++;
        end
    end

    task automatic wait_done(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < 12);
    endtask

    task automatic mul(input logic [4:0] x, input logic [4:0] y, input int exp);
        int k;
        start = 1'b1; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        wait_done(k);
        chk("latency", k, 5);
        chk("product_at_done", int'(product), exp);
        @(negedge clk);
        chk("product_held", int'(product), exp);
    endtask

    initial begin
        int k, d0;
        repeat (2) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_product", int'(product), 0);
        rst = 1'b0;
        @(negedge clk);

        mul(5'd31, 5'd31, 961);
        mul(5'd0, 5'd17, 0);
        mul(5'd1, 5'd31, 31);
        mul(5'd16, 5'd16, 256);
        mul(5'd31, 5'd1, 31);

        // Asynchronous reset mid-cycle clears outputs without a clock edge.
        mul(5'd31, 5'd31, 961);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_done", int'(done), 0);
        chk("async_rst_product", int'(product), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // start while busy is ignored
        d0 = dut_dones;
        start = 1'b1; a = 5'd3; b = 5'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 5'd7; b = 5'd7;
        @(negedge clk);
        start = 1'b0;
        wait_done(k);
        chk("busy_protect_product", int'(product), 15);
        repeat (4) @(negedge clk);
        chk("busy_protect_dones", dut_dones - d0, 1);

        // Back-to-back with start held: second operation accepted in DONE
        start = 1'b1; a = 5'd6; b = 5'd7;
        @(negedge clk);
        wait_done(k);
        chk("b2b_first", int'(product), 42);
        a = 5'd9; b = 5'd9;
        @(negedge clk);
        start = 1'b0;
        wait_done(k);
        chk("b2b_gap", k + 1, 6);
        chk("b2b_second", int'(product), 81);
        @(negedge clk);

        // Reset during RUN abandons the operation
        d0 = dut_dones;
        start = 1'b1; a = 5'd31; b = 5'd31;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midop_rst_product", int'(product), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("midop_no_done", dut_dones - d0, 0);
        mul(5'd2, 5'd3, 6);

        for (int x = 0; x < 32; x++)
            for (int y = 0; y < 32; y++)
                mul(5'(x), 5'(y), x * y);

        for (int i = 0; i < 1500; i++) begin
            start = ($urandom_range(0, 3) == 0);
            a = $urandom; b = $urandom;
            @(negedge clk);
        end
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("done_count", dut_dones, m_completions);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
